// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch-side prediction and ID-side resolution bus for branch_predictor
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              id_valid;
  logic              id_is_branch;
  logic [ADDR_W-1:0] id_pc;
  logic              id_taken;
  logic [ADDR_W-1:0] id_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_addr;

  modport master (
    output if_pc, id_valid, id_is_branch, id_pc, id_taken, id_target,
    input  pred_taken, pred_target, mispredict, redirect_addr
  );

  modport slave (
    input  if_pc, id_valid, id_is_branch, id_pc, id_taken, id_target,
    output pred_taken, pred_target, mispredict, redirect_addr
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB predictor with ID-stage check, table update and perf counters
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  branch_predictor_if.slave bus,
  output logic [31:0]       br_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic              pq_taken;
  logic [ADDR_W-1:0] pq_target;

  logic [IDX_W-1:0]  if_idx;
  logic [TAG_W-1:0]  if_tag;
  logic              if_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic [IDX_W-1:0]  id_idx;
  logic [TAG_W-1:0]  id_tag;
  logic              id_hit;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect;

  always_comb begin
    if_idx      = IDX_W'(bus.if_pc >> 2);
    if_tag      = TAG_W'(bus.if_pc >> (IDX_W + 2));
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
    pred_target = pred_taken ? target_q[if_idx] : '0;
  end

  always_comb begin
    id_idx = IDX_W'(bus.id_pc >> 2);
    id_tag = TAG_W'(bus.id_pc >> (IDX_W + 2));
    id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  end

  // The delay slot is already in flight, so a fall-through resumes at pc+8.
  always_comb begin
    mispredict = 1'b0;
    redirect   = '0;
    if (bus.id_valid) begin
      if (bus.id_is_branch)
        mispredict = (pq_taken != bus.id_taken) ||
                     (bus.id_taken && (pq_target != bus.id_target));
      else
        mispredict = pq_taken;
      redirect = (bus.id_is_branch && bus.id_taken) ? bus.id_target
                                                    : bus.id_pc + ADDR_W'(8);
    end
  end

  assign bus.pred_taken    = pred_taken;
  assign bus.pred_target   = pred_target;
  assign bus.mispredict    = mispredict;
  assign bus.redirect_addr = redirect;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pq_taken  <= 1'b0;
      pq_target <= '0;
    end else if (flush) begin
      pq_taken  <= 1'b0;
      pq_target <= '0;
    end else if (!stall) begin
      pq_taken  <= pred_taken;
      pq_target <= pred_target;
    end
  end

  // IF reads in the update cycle see the pre-update entry; there is no bypass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (bus.id_valid) begin
      if (bus.id_is_branch) begin
        if (id_hit) begin
          if (bus.id_taken) begin
            if (ctr_q[id_idx] != CTR_MAX)
              ctr_q[id_idx] <= ctr_q[id_idx] + CTR_W'(1);
            target_q[id_idx] <= bus.id_target;
          end else if (ctr_q[id_idx] != '0) begin
            ctr_q[id_idx] <= ctr_q[id_idx] - CTR_W'(1);
          end
        end else if (bus.id_taken) begin
          valid_q[id_idx]  <= 1'b1;
          tag_q[id_idx]    <= id_tag;
          target_q[id_idx] <= bus.id_target;
          ctr_q[id_idx]    <= CTR_INIT;
        end
      end else if (id_hit) begin
        valid_q[id_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (bus.id_valid && bus.id_is_branch && (br_cnt != 32'hFFFF_FFFF))
        br_cnt <= br_cnt + 32'd1;
      if (bus.id_valid && mispredict && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor against a table-level reference model
module tb_branch_predictor;
  localparam int ENT = 16;

  typedef struct packed {
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] ra;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  branch_predictor_if #(.ADDR_W(32)) bus();

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .bus      (bus),
    .br_cnt   (br_cnt),
    .miss_cnt (miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  int unsigned m_tgt   [ENT];
  int          m_ctr   [ENT];
  bit          m_pq_t;
  int unsigned m_pq_tg;
  int unsigned m_br;
  int unsigned m_miss;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pred_taken",    {31'd0, bus.pred_taken}, {31'd0, e.pt});
        chk("pred_target",   bus.pred_target,         e.ptg);
        chk("mispredict",    {31'd0, bus.mispredict}, {31'd0, e.mp});
        chk("redirect_addr", bus.redirect_addr,       e.ra);
        chk("br_cnt",        br_cnt,                  e.bc);
        chk("miss_cnt",      miss_cnt,                e.mc);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_pq_t = 0; m_pq_tg = 0; m_br = 0; m_miss = 0;
  endtask

  // One fetch/resolve cycle: drive, predict from the model, queue the expectation, advance the model.
  task automatic cycle(input bit r, input bit s, input bit f, input logic [31:0] ipc,
                       input bit v, input bit b, input logic [31:0] ipd,
                       input bit t, input logic [31:0] tg);
    exp_t        e;
    int          ii, di;
    bit          ptk, hit_id, mp;
    int unsigned ptg;
    logic [31:0] ra;
    rst = r; stall = s; flush = f;
    bus.if_pc = ipc; bus.id_valid = v; bus.id_is_branch = b;
    bus.id_pc = ipd; bus.id_taken = t; bus.id_target = tg;
    ii  = int'((ipc >> 2) % ENT);
    ptk = m_valid[ii] && (m_tag[ii] == (ipc >> 6)) && (m_ctr[ii] >= 2);
    ptg = ptk ? m_tgt[ii] : 0;
    mp = 0;
    ra = 0;
    if (v) begin
      mp = b ? ((m_pq_t != t) || (t && (m_pq_tg != tg))) : m_pq_t;
      ra = (b && t) ? tg : ipd + 32'd8;
    end
    e = '{pt: ptk, ptg: ptg, mp: mp, ra: ra, bc: m_br, mc: m_miss};
    if (r) exp_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      if (f) begin
        m_pq_t = 0; m_pq_tg = 0;
      end else if (!s) begin
        m_pq_t = ptk; m_pq_tg = ptg;
      end
      if (v) begin
        di     = int'((ipd >> 2) % ENT);
        hit_id = m_valid[di] && (m_tag[di] == (ipd >> 6));
        if (b) begin
          if (hit_id) begin
            if (t) begin
              m_ctr[di] = (m_ctr[di] + 1 > 3) ? 3 : m_ctr[di] + 1;
              m_tgt[di] = tg;
            end else begin
              m_ctr[di] = (m_ctr[di] - 1 < 0) ? 0 : m_ctr[di] - 1;
            end
          end else if (t) begin
            m_valid[di] = 1; m_tag[di] = ipd >> 6; m_tgt[di] = tg; m_ctr[di] = 2;
          end
          if (m_br != 32'hFFFF_FFFF) m_br++;
        end else if (hit_id) begin
          m_valid[di] = 0;
        end
        if (mp && (m_miss != 32'hFFFF_FFFF)) m_miss++;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    cycle(1, 0, 0, ipc, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc, prev_pc, ipd, tg;
    bit v, b, t, s, f;
    model_reset();
    cycle(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    idle(32'h0040_0010);
    // cold taken, then predicted next cycle
    cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 1, 32'h0040_0100);
    idle(32'h0040_0020);
    // hysteresis
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 1, 32'h0040_0100);
    cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 0, 32'h0040_0100);
    cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 0, 32'h0040_0100);
    idle(32'h0040_0020);
    // re-train to taken, alias, then invalidate via non-branch
    cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 1, 32'h0040_0100);
    idle(32'h0040_0020);
    idle(32'h0040_0060);
    idle(32'h0040_0020);
    cycle(1, 0, 0, 32'h0040_0020, 1, 0, 32'h0040_0020, 0, 32'h0);
    idle(32'h0040_0020);
    // stall holds, flush wins over stall
    cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 1, 32'h0040_0100);
    idle(32'h0040_0020);
    cycle(1, 1, 0, 32'h0040_0030, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 32'h0040_0040, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 32'h0040_0044, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 1, 32'h0040_0100);
    cycle(1, 1, 1, 32'h0040_0020, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 1, 32'h0040_0100);
    // target change on a hit, then redirect wrap-around
    cycle(1, 0, 0, 32'h0040_0020, 1, 1, 32'h0040_0020, 1, 32'h0040_0200);
    idle(32'h0040_0020);
    cycle(1, 0, 0, 32'h0040_0000, 1, 0, 32'hFFFF_FFFC, 0, 32'h0);

    prev_pc = 32'h0040_0000;
    for (int n = 0; n < 600; n++) begin
      pc  = 32'h0040_0000 + ($urandom_range(0, 2) * 64) + ($urandom_range(0, 15) * 4);
      v   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 3) != 0);
      t   = $urandom_range(0, 1) != 0;
      s   = ($urandom_range(0, 7) == 0);
      f   = ($urandom_range(0, 15) == 0);
      ipd = ($urandom_range(0, 3) != 0) ? prev_pc
            : 32'h0040_0000 + ($urandom_range(0, 2) * 64) + ($urandom_range(0, 15) * 4);
      case ($urandom_range(0, 2))
        0:       tg = 32'h0040_0100;
        1:       tg = 32'h0040_0200;
        default: tg = $urandom & 32'hFFFF_FFFC;
      endcase
      if (n == 300) begin
        cycle(0, 0, 0, pc, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, pc, 0, 0, 0, 0, 0);
      end else begin
        cycle(1, s, f, pc, v, b, ipd, t, tg);
      end
      if (!s) prev_pc = pc;
    end
    @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction and resolution unit for the five-stage MIPS32 core. A direct-mapped branch target buffer with saturating direction counters predicts control transfers for the instruction at the IF PC. The prediction travels with the instruction to ID, where it is checked against the resolved branch flag and address from ID-stage branch generation. On disagreement the block raises a mispredict with the correct redirect address, updates its table, and maintains branch and mispredict performance counters.

## Interface
- ENTRIES, 16: BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- ADDR_W, 32: PC and target width
- CTR_W, 2: direction counter width, ≥1
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- stall  in  1  IF/ID stall; holds prediction pipeline register
- flush  in  1  IF/ID flush; clears prediction pipeline register
- if_pc  in  ADDR_W  PC of instruction being fetched
- pred_taken  out  1  prediction for if_pc
- pred_target  out  ADDR_W  predicted target; 0 when pred_taken=0
- id_valid  in  1  one-cycle pulse per instruction in ID; low during ID stall
- id_is_branch  in  1  ID instruction is BEQ/BNE/BLTZ/BLEZ/JAL/JR/JALR
- id_pc  in  ADDR_W  PC of ID instruction
- id_taken  in  1  resolved branch flag
- id_target  in  ADDR_W  resolved branch address
- mispredict  out  1  prediction wrong for ID instruction
- redirect_addr  out  ADDR_W  correct fetch address after delay slot
- br_cnt  out  32  resolved branches
- miss_cnt  out  32  mispredicted instructions

## Operation
- Entry: valid, tag = pc[ADDR_W-1:IDX_W+2], target[ADDR_W], ctr[CTR_W]. Index = pc[IDX_W+1:2].
- Lookup (combinational): hit = valid && tag match at if_pc index; pred_taken = hit && ctr[MSB]; pred_target = pred_taken ? target : 0.
- Prediction register pq = {pq_taken, pq_target}: on edge, flush → 0 (priority over stall); else stall → hold; else ← {pred_taken, pred_target}.
- Check (combinational, only when id_valid; else mispredict=0, redirect_addr=0):
  - branch: mispredict = (pq_taken != id_taken) || (id_taken && pq_target != id_target).
  - non-branch: mispredict = pq_taken.
  - redirect_addr = (id_is_branch && id_taken) ? id_target : id_pc+8 (delay slot already fetched; modulo 2^ADDR_W).
- Update on edge when id_valid, at id_pc index:
  - branch, hit: ctr saturating +1 if taken, −1 if not (bounds 0, 2^CTR_W−1); target ← id_target if taken.
  - branch, miss, taken: allocate/overwrite; valid=1, tag, target ← id_target, ctr ← 2^(CTR_W−1) (weakly taken).
  - branch, miss, not taken: no change.
  - non-branch, hit: valid ← 0. Non-branch, miss: no change.
- Counters: br_cnt +1 on id_valid && id_is_branch; miss_cnt +1 on id_valid && mispredict; both saturate at 0xFFFFFFFF.
- Reset (rst=0 at edge): all valid=0, ctr=0, target=0, pq=0, br_cnt=0, miss_cnt=0. Outputs during/after reset: pred_taken=0, pred_target=0, mispredict=0, redirect_addr=0 (id_valid must be low).

## Timing
- Prediction: zero latency from if_pc; registered into pq at end of IF cycle.
- Check: zero latency, same cycle as id_valid.
- Table update visible one cycle after id_valid edge. Same-cycle IF read of the entry being written returns old contents (no bypass).
- Stall and flush same cycle: flush wins. Reset mid-stream discards pq and table contents.

## Test plan
- Reset: rst=0 two cycles, release, if_pc=0x00400010 → pred_taken=0, pred_target=0, br_cnt=miss_cnt=0.
- Cold taken: id_pc=0x00400020, branch, taken, target 0x00400100, pq=0 → mispredict=1, redirect=0x00400100, miss_cnt=1; next cycle if_pc=0x00400020 → pred_taken=1, pred_target=0x00400100.
- Hysteresis: three further correctly predicted takens (ctr=3, no mispredict); one not-taken → mispredict=1, redirect=0x00400028, still predicts taken; second not-taken → pred_taken=0 next cycle.
- Alias/invalidate: if_pc=0x00400060 (same index 8, other tag) → pred_taken=0; non-branch at 0x00400020 with pq_taken=1 → mispredict=1, redirect=0x00400028, entry invalid next cycle.
- Stall/flush: pq loaded with taken/0x00400100; stall=1 three cycles with changing if_pc → pq holds; stall=1, flush=1 → pq=0.
- Target change: hit taken branch resolves taken to 0x00400200 with pq_target=0x00400100 → mispredict=1, redirect=0x00400200, table target updated.
